// File: rtl/dff_mem_pkg.sv
// Shared constants, types and FSM encoding for the DFF RAM controller.
// RAM_BYTES/ADDR_W size the RAM; STROBE_ON/OFF give the active-low levels.
package dff_mem_pkg;

    localparam int RAM_BYTES = 16;
    localparam int ADDR_W    = $clog2(RAM_BYTES);

    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        WR_PULSE,
        RD_ISSUE,
        RD_CAP,
        RD_RESP,
        VFY_ISSUE,
        VFY_CAP
    } state_e;

    // RAM_BYTES is a power of two, so a plain increment wraps to 0.
    function automatic addr_t addr_next(input addr_t a);
        return a + addr_t'(1);
    endfunction

endpackage

// File: rtl/dff_mem_ctrl_if.sv
// Bus-side handshakes of the DFF RAM controller: request, write and read streams.
// master = CPU/loader side, slave = controller side.
interface dff_mem_ctrl_if;
    import dff_mem_pkg::*;

    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    addr_t      req_addr;
    addr_t      req_len;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;

    modport master (
        output req_valid, req_write, req_addr, req_len,
        output wr_valid, wr_data, rd_ready,
        input  req_ready, wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_len,
        input  wr_valid, wr_data, rd_ready,
        output req_ready, wr_ready, rd_valid, rd_data
    );

endinterface

// File: rtl/dff_mem_addr_ctr.sv
// Burst address register and beat counter: load on accept, step per beat.
// Ports: clk, rst_n, load/load_addr/load_len, step, addr (RAM mar), last.
module dff_mem_addr_ctr
    import dff_mem_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  step,
    input  addr_t load_addr,
    input  addr_t load_len,
    output addr_t addr,
    output logic  last
);

    addr_t cnt;
    addr_t len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            cnt  <= '0;
            len  <= '0;
        end else if (load) begin
            addr <= load_addr;
            cnt  <= '0;
            len  <= load_len;
        end else if (step) begin
            addr <= addr_next(addr);
            cnt  <= cnt + addr_t'(1);
        end
    end

    assign last = (cnt == len);

endmodule

// File: rtl/dff_mem_ctrl.sv
// Burst initiator for the 16-byte DFF RAM; only driver of its mar/ce_n/lr_n.
// Ports: clk, rst_n, bus (req/wr/rd streams), busy, mar, mem_din, mem_dout,
// ce_n, lr_n, verify_err. Define DFF_MEM_VERIFY_EN for write read-back checking.
module dff_mem_ctrl
    import dff_mem_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    dff_mem_ctrl_if.slave bus,
    output logic          busy,
    output addr_t         mar,
    output logic [7:0]    mem_din,
    input  logic [7:0]    mem_dout,
    output logic          ce_n,
    output logic          lr_n,
    output logic          verify_err
);

    state_e state;
    logic   is_wr;
    logic   accept;
    logic   beat_done;
    logic   last;

    // The address register doubles as the registered mar output.
    dff_mem_addr_ctr u_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .step      (beat_done),
        .load_addr (bus.req_addr),
        .load_len  (bus.req_len),
        .addr      (mar),
        .last      (last)
    );

    always_comb begin
        accept    = (state == IDLE) && bus.req_valid && bus.req_ready;
        beat_done = 1'b0;
        unique case (1'b1)
            (state == RD_RESP): beat_done = bus.rd_ready;
`ifdef DFF_MEM_VERIFY_EN
            (state == VFY_CAP): beat_done = 1'b1;
`else
            (state == WR_PULSE): beat_done = 1'b1;
`endif
            default: beat_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            is_wr         <= 1'b0;
            ce_n          <= STROBE_OFF;
            lr_n          <= STROBE_OFF;
            mem_din       <= '0;
            bus.rd_data   <= '0;
            bus.rd_valid  <= 1'b0;
            bus.wr_ready  <= 1'b0;
            bus.req_ready <= 1'b1;
            busy          <= 1'b0;
`ifdef DFF_MEM_VERIFY_EN
            verify_err    <= 1'b0;
`endif
        end else begin
            // Strobes default high so each low phase lasts one cycle.
            ce_n <= STROBE_OFF;
            lr_n <= STROBE_OFF;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        bus.req_ready <= 1'b0;
                        busy          <= 1'b1;
                        is_wr         <= bus.req_write;
`ifdef DFF_MEM_VERIFY_EN
                        verify_err    <= 1'b0;
`endif
                        if (bus.req_write) begin
                            state        <= WR_WAIT;
                            bus.wr_ready <= 1'b1;
                        end else begin
                            state <= RD_ISSUE;
                            ce_n  <= STROBE_ON;
                        end
                    end
                end
                WR_WAIT: begin
                    if (bus.wr_valid) begin
                        bus.wr_ready <= 1'b0;
                        mem_din      <= bus.wr_data;
                        lr_n         <= STROBE_ON;
                        state        <= WR_PULSE;
                    end
                end
                WR_PULSE: begin
`ifdef DFF_MEM_VERIFY_EN
                    state <= VFY_ISSUE;
                    ce_n  <= STROBE_ON;
`endif
                end
`ifdef DFF_MEM_VERIFY_EN
                VFY_ISSUE: state <= VFY_CAP;
                VFY_CAP: begin
                    // mem_din still holds the byte just written.
                    if (mem_dout != mem_din) verify_err <= 1'b1;
                end
`endif
                RD_ISSUE: state <= RD_CAP;
                RD_CAP: begin
                    bus.rd_data  <= mem_dout;
                    bus.rd_valid <= 1'b1;
                    state        <= RD_RESP;
                end
                RD_RESP: begin
                    if (bus.rd_ready) bus.rd_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            // End of a beat overrides the per-state next state.
            if (beat_done) begin
                if (last) begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                    busy          <= 1'b0;
                end else if (is_wr) begin
                    state        <= WR_WAIT;
                    bus.wr_ready <= 1'b1;
                end else begin
                    state <= RD_ISSUE;
                    ce_n  <= STROBE_ON;
                end
            end
        end
    end

`ifndef DFF_MEM_VERIFY_EN
    assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_dff_mem_ctrl.sv
// Bench for dff_mem_ctrl with a behavioural 16-byte DFF RAM and a
// byte-array/queue model of the expected bus and strobe traffic.
module tb_dff_mem_ctrl;
    import dff_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dff_mem_ctrl_if bus();

    logic       busy, ce_n, lr_n, verify_err;
    addr_t      mar;
    logic [7:0] mem_din, mem_dout;

    dff_mem_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .busy       (busy),
        .mar        (mar),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .ce_n       (ce_n),
        .lr_n       (lr_n),
        .verify_err (verify_err)
    );

    // DFF RAM: write on lr_n low, read into data_out on ce_n low.
    logic [7:0] ram [RAM_BYTES];
    logic [7:0] ram_q;
    logic       ram_clr = 1'b1;
    logic       force_zero = 1'b0;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < RAM_BYTES; i++) ram[i] <= 8'hE0 | 8'(i);
        end else begin
            if (!lr_n) ram[mar] <= mem_din;
            if (!ce_n) ram_q <= ram[mar];
        end
    end
    assign mem_dout = force_zero ? 8'h00 : ram_q;

    typedef struct {
        addr_t      a;
        logic [7:0] d;
    } wbeat_t;

    logic [7:0] mdl [RAM_BYTES];
    wbeat_t     exp_wr[$];
    logic [7:0] exp_rd[$];
    logic [7:0] rd_log[$];
    addr_t      mar_log[$];
    logic [7:0] wq[$];
    logic       exp_verr = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         ce_pulses = 0;
    int         lr_pulses = 0;
    int         accepts = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Per-cycle compare against the model queues.
    initial begin
        logic pce, plr;
        pce = 1'b1;
        plr = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                pce = 1'b1;
                plr = 1'b1;
                continue;
            end
            chk("strobe_excl", 32'(ce_n | lr_n), 1);
            chk("busy_vs_ready", 32'(busy), 32'(!bus.req_ready));
            if (!busy) begin
                chk("idle_strobes", 32'(ce_n & lr_n), 1);
                chk("verify_err", 32'(verify_err), 32'(exp_verr));
            end
            if (!ce_n) begin
                ce_pulses++;
                chk("ce_single", 32'(pce), 1);
            end
            if (!lr_n) begin
                lr_pulses++;
                chk("lr_single", 32'(plr), 1);
                mar_log.push_back(mar);
                chk("wr_expected", 32'(exp_wr.size() != 0), 1);
                if (exp_wr.size() != 0) begin
                    chk("wr_mar", 32'(mar), 32'(exp_wr[0].a));
                    chk("wr_din", 32'(mem_din), 32'(exp_wr[0].d));
                    void'(exp_wr.pop_front());
                end
            end
            if (bus.rd_valid) begin
                chk("rd_expected", 32'(exp_rd.size() != 0), 1);
                if (exp_rd.size() != 0) begin
                    chk("rd_data", 32'(bus.rd_data), 32'(exp_rd[0]));
                    if (bus.rd_ready) begin
                        rd_log.push_back(bus.rd_data);
                        void'(exp_rd.pop_front());
                    end
                end
            end
            if (bus.req_valid && bus.req_ready) accepts++;
            pce = ce_n;
            plr = lr_n;
        end
    end

    // All tasks are entered and left at a falling edge.
    task automatic wait_idle();
        int n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b0;
        chk("idle_reached", 32'(bus.req_ready), 1);
    endtask

    task automatic do_req(input bit wr, input addr_t a, input addr_t l,
                          input bit hold, output bit ok);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_len   = l;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = bus.req_ready;
        chk("req_ready", 32'(bus.req_ready), 1);
        if (!ok) begin
            bus.req_valid = 1'b0;
            return;
        end
        if (!wr)
            for (int i = 0; i <= int'(l); i++)
                exp_rd.push_back(mdl[addr_t'(int'(a) + i)]);
        @(negedge clk);
        exp_verr = 1'b0;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wr_burst(input addr_t a, input addr_t l, input logic ev);
        bit ok;
        int n;
        do_req(1'b1, a, l, 1'b0, ok);
        if (!ok) return;
        for (int i = 0; i <= int'(l); i++) begin
            exp_wr.push_back('{a: addr_t'(int'(a) + i), d: wq[i]});
            mdl[addr_t'(int'(a) + i)] = wq[i];
        end
        for (int i = 0; i <= int'(l); i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = wq[i];
            n = 0;
            while (!bus.wr_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("wr_ready", 32'(bus.wr_ready), 1);
            @(negedge clk);
        end
        exp_verr     = ev;
        bus.wr_valid = 1'b0;
        wait_idle();
    endtask

    task automatic rd_burst(input addr_t a, input addr_t l,
                            input int stall_beat, input int stall_n,
                            input bit hold);
        bit ok;
        int n;
        rd_log.delete();
        do_req(1'b0, a, l, hold, ok);
        if (!ok) return;
        for (int b = 0; b <= int'(l); b++) begin
            bus.rd_ready = (b != stall_beat);
            n = 0;
            while (!bus.rd_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("rd_valid_wait", 32'(bus.rd_valid), 1);
            if (b == stall_beat) begin
                repeat (stall_n) @(negedge clk);
                bus.rd_ready = 1'b1;
            end
            @(negedge clk);
        end
        bus.rd_ready = 1'b1;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int c0, l0, a0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_ready  = 1'b1;
        for (int i = 0; i < RAM_BYTES; i++) mdl[i] = 8'hE0 | 8'(i);

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ce_n", 32'(ce_n), 1);
        chk("rst_lr_n", 32'(lr_n), 1);
        chk("rst_mar", 32'(mar), 0);
        chk("rst_din", 32'(mem_din), 0);
        chk("rst_rd_data", 32'(bus.rd_data), 0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 0);
        chk("rst_wr_ready", 32'(bus.wr_ready), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_verify_err", 32'(verify_err), 0);
        ram_clr = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);

        // 1: single write then single read at address 3
        wq = '{8'hA5};
        mar_log.delete();
        l0 = lr_pulses;
        wr_burst(4'd3, 4'd0, 1'b0);
        chk("t1_lr_count", 32'(lr_pulses - l0), 1);
        chk("t1_wr_mar", 32'(mar_log[0]), 3);
        rd_log.delete();
        do_req(1'b0, 4'd3, 4'd0, 1'b0, ok);
        chk("t1_ce_issue", 32'(ce_n), 0);
        chk("t1_mar_issue", 32'(mar), 3);
        @(negedge clk);
        chk("t1_cap_no_valid", 32'(bus.rd_valid), 0);
        @(negedge clk);
        chk("t1_valid", 32'(bus.rd_valid), 1);
        chk("t1_data", 32'(bus.rd_data), 32'h A5);
        wait_idle();

        // 2: wrapping write burst and read-back
        wq = '{8'h11, 8'h22, 8'h33, 8'h44};
        mar_log.delete();
        wr_burst(4'd14, 4'd3, 1'b0);
        chk("t2_mar_n", 32'(mar_log.size()), 4);
        chk("t2_mar0", 32'(mar_log[0]), 14);
        chk("t2_mar1", 32'(mar_log[1]), 15);
        chk("t2_mar2", 32'(mar_log[2]), 0);
        chk("t2_mar3", 32'(mar_log[3]), 1);
        rd_burst(4'd14, 4'd3, -1, 0, 1'b0);
        chk("t2_rd0", 32'(rd_log[0]), 32'h11);
        chk("t2_rd1", 32'(rd_log[1]), 32'h22);
        chk("t2_rd2", 32'(rd_log[2]), 32'h33);
        chk("t2_rd3", 32'(rd_log[3]), 32'h44);

        // 3: whole-RAM read with a 5-cycle stall on beat 2
        c0 = ce_pulses;
        rd_burst(4'd0, 4'd15, 2, 5, 1'b0);
        chk("t3_ce_count", 32'(ce_pulses - c0), 16);
        chk("t3_rd_n", 32'(rd_log.size()), 16);
        chk("t3_rd0", 32'(rd_log[0]), 32'h33);
        chk("t3_rd2", 32'(rd_log[2]), 32'hE2);
        chk("t3_rd3", 32'(rd_log[3]), 32'hA5);
        chk("t3_rd15", 32'(rd_log[15]), 32'h22);

        // 4: reset during WR_PULSE of beat 2 of a 4-beat write at 8
        do_req(1'b1, 4'd8, 4'd3, 1'b0, ok);
        wq = '{8'hC1, 8'hC2, 8'hC3};
        for (int i = 0; i < 3; i++)
            exp_wr.push_back('{a: addr_t'(8 + i), d: wq[i]});
        mdl[8] = 8'hC1;
        mdl[9] = 8'hC2;
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = wq[i];
            c0 = 0;
            while (!bus.wr_ready && c0 < 50) begin
                @(negedge clk);
                c0++;
            end
            chk("t4_wr_ready", 32'(bus.wr_ready), 1);
            @(negedge clk);
        end
        chk("t4_in_pulse", 32'(lr_n), 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t4_lr_async", 32'(lr_n), 1);
        chk("t4_ce_async", 32'(ce_n), 1);
        bus.wr_valid = 1'b0;
        exp_wr.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t4_req_ready", 32'(bus.req_ready), 1);
        chk("t4_busy", 32'(busy), 0);
        rd_burst(4'd8, 4'd3, -1, 0, 1'b0);
        chk("t4_rd8", 32'(rd_log[0]), 32'hC1);
        chk("t4_rd9", 32'(rd_log[1]), 32'hC2);
        chk("t4_rd10", 32'(rd_log[2]), 32'hEA);
        chk("t4_rd11", 32'(rd_log[3]), 32'hEB);

        // 5: req_valid held high for a whole read burst
        a0 = accepts;
        c0 = ce_pulses;
        rd_burst(4'd4, 4'd3, -1, 0, 1'b1);
        chk("t5_accepts", 32'(accepts - a0), 1);
        chk("t5_ce_count", 32'(ce_pulses - c0), 4);
        chk("t5_rd0", 32'(rd_log[0]), 32'hE4);

`ifdef DFF_MEM_VERIFY_EN
        // 6: read-back mismatch sets verify_err until the next accept
        wq = '{8'h5A};
        force_zero = 1'b1;
        wr_burst(4'd5, 4'd0, 1'b1);
        force_zero = 1'b0;
        @(negedge clk);
        chk("t6_verr_set", 32'(verify_err), 1);
        rd_burst(4'd5, 4'd0, -1, 0, 1'b0);
        chk("t6_verr_clr", 32'(verify_err), 0);
        chk("t6_rd", 32'(rd_log[0]), 32'h5A);
`endif

        repeat (3) @(negedge clk);
        chk("end_wr_q", 32'(exp_wr.size()), 0);
        chk("end_rd_q", 32'(exp_rd.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
